kernel_ctrl: RTL

//  Sequencer for one WIDTHxHEIGHT systolic kernel: loads weights and bias, skews and streams input

---
 rtl/kernel_pkg.sv | 20 ++
 rtl/skew_buffer.sv | 36 +++
 rtl/kernel_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/kernel_pkg.sv
// Shared types and helpers for the systolic kernel sequencer.
// Imported by kernel_ctrl and its skew buffer.
package kernel_pkg;

   localparam int DEF_BITWIDTH = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } kctrl_state_t;

   // Cycles from row-0 element entering the kernel to its result appearing.
   function automatic int res_lat(input int width, input int height);
      return width + height;
   endfunction

endpackage

// File: rtl/skew_buffer.sv
// Triangular delay line: lane i of the input vector is delayed by i cycles
// so the kernel sees the classic systolic diagonal wavefront.
module skew_buffer
   import kernel_pkg::*;
#(
   parameter int HEIGHT   = 5,
   parameter int BITWIDTH = DEF_BITWIDTH
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [HEIGHT*BITWIDTH-1:0] i_data,
   output logic [HEIGHT*BITWIDTH-1:0] o_data
);

   for (genvar i = 0; i < HEIGHT; i++) begin : g_lane
      if (i == 0) begin : g_pass
         assign o_data[BITWIDTH-1:0] = i_data[BITWIDTH-1:0];
      end else begin : g_dly
         logic [BITWIDTH-1:0] sr [i];

         // NOTE: these small delay arrays are reset so the kernel sees zeros,
         // not stale data, after a reset or abort; large RAMs would not be.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               for (int k = 0; k < i; k++) sr[k] <= '0;
            end else begin
               sr[0] <= i_data[i*BITWIDTH +: BITWIDTH];
               for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
            end
         end

         assign o_data[i*BITWIDTH +: BITWIDTH] = sr[i-1];
      end
   end

endmodule

// File: rtl/kernel_ctrl.sv
// Sequencer for one WIDTHxHEIGHT systolic kernel: weight/bias load, skewed
// data streaming with bubble insertion, drain, and result-valid tracking.
module kernel_ctrl
   import kernel_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int HEIGHT   = 5,
   parameter int BITWIDTH = DEF_BITWIDTH,
   parameter int RES_LAT  = res_lat(WIDTH, HEIGHT),
   parameter int CNT_W    = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [CNT_W-1:0]           i_num_vec,
   input  logic                       i_w_valid,
   output logic                       o_w_ready,
   input  logic [WIDTH*BITWIDTH-1:0]  i_w_row,
   input  logic [BITWIDTH-1:0]        i_bias,
   input  logic                       i_d_valid,
   output logic                       o_d_ready,
   input  logic [HEIGHT*BITWIDTH-1:0] i_d_vec,
   output logic                       o_loading_weight,
   output logic [WIDTH*BITWIDTH-1:0]  o_weight,
   output logic [BITWIDTH-1:0]        o_bias,
   output logic [HEIGHT*BITWIDTH-1:0] o_data,
   output logic                       o_res_valid,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int VP_D = RES_LAT + HEIGHT;
   localparam int WC_W = $clog2(HEIGHT + 1);

   kctrl_state_t               state, state_nxt;
   logic [CNT_W-1:0]           num_vec_q;
   logic [CNT_W-1:0]           acc_cnt;
   logic [WC_W-1:0]            w_cnt;
   logic [BITWIDTH-1:0]        bias_q;
   logic [HEIGHT*BITWIDTH-1:0] in_reg;
   logic [VP_D-1:0]            vpipe;

   logic w_hs;
   logic d_hs;
   logic last_w;
   logic last_d;

   assign o_w_ready = (state == S_LOAD_W);
   assign o_d_ready = (state == S_STREAM) && (acc_cnt < num_vec_q);
   assign o_busy    = (state != S_IDLE);
   assign o_done    = (state == S_DONE);

   assign w_hs   = i_w_valid && o_w_ready;
   assign d_hs   = i_d_valid && o_d_ready;
   assign last_w = w_hs && (w_cnt == WC_W'(HEIGHT - 1));
   assign last_d = d_hs && ((acc_cnt + 1'b1) == num_vec_q);

   // The kernel shifts weights only on a real handshake; bias stays visible
   // afterwards so the kernel keeps the value that arrived with the last row.
   assign o_loading_weight = w_hs;
   assign o_weight         = w_hs ? i_w_row : '0;
   assign o_bias           = w_hs ? i_bias : bias_q;
   assign o_res_valid      = vpipe[VP_D-1];

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_start) state_nxt = S_LOAD_W;
         S_LOAD_W: if (last_w) state_nxt = (num_vec_q == '0) ? S_DRAIN : S_STREAM;
         S_STREAM: if (last_d) state_nxt = S_DRAIN;
         S_DRAIN:  if (vpipe == '0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         num_vec_q <= '0;
         acc_cnt   <= '0;
         w_cnt     <= '0;
         bias_q    <= '0;
         in_reg    <= '0;
         vpipe     <= '0;
      end else begin
         state  <= state_nxt;
         vpipe  <= {vpipe[VP_D-2:0], d_hs};
         // Cycles without a handshake inject an all-zero bubble.
         in_reg <= d_hs ? i_d_vec : '0;
         if (w_hs) bias_q <= i_bias;
         if (state == S_IDLE && i_start) begin
            num_vec_q <= i_num_vec;
            acc_cnt   <= '0;
            w_cnt     <= '0;
         end
         if (w_hs) w_cnt <= w_cnt + 1'b1;
         if (d_hs) acc_cnt <= acc_cnt + 1'b1;
      end
   end

   skew_buffer #(
      .HEIGHT   (HEIGHT),
      .BITWIDTH (BITWIDTH)
   ) u_skew (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (in_reg),
      .o_data (o_data)
   );

endmodule
